// File: rtl/fulladder_4to1mux.sv
// Registered 1-bit full adder whose sum and carry each come from a 4:1 mux
// tree selected by {a,b}. Optional sticky self-check flag: FA_SELFCHECK_EN.

module fa_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y_c
);
  assign y_c = sel ? d1 : d0;
endmodule

module fa_mux4 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y_c
);
  logic lo_c;
  logic hi_c;

  // First stage resolves sel[0] within each pair; the last stage picks the pair.
  fa_mux2 u_lo  (.d0(d[0]), .d1(d[1]), .sel(sel[0]), .y_c(lo_c));
  fa_mux2 u_hi  (.d0(d[2]), .d1(d[3]), .sel(sel[0]), .y_c(hi_c));
  fa_mux2 u_out (.d0(lo_c), .d1(hi_c), .sel(sel[1]), .y_c(y_c));
endmodule

module fulladder_4to1mux (
  input  logic clk,
  input  logic rst,
  input  logic cin,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
`ifdef FA_SELFCHECK_EN
  ,
  output logic err
`endif
);
  logic [1:0] sel_c;
  logic [3:0] sum_data_c;
  logic [3:0] carry_data_c;
  logic       sum_c;
  logic       carry_c;
  logic       s_d, s_q;
  logic       c_d, c_q;

  assign sel_c        = {a, b};
  assign sum_data_c   = {cin, ~cin, ~cin, cin};
  assign carry_data_c = {1'b1, cin, cin, 1'b0};

  fa_mux4 u_sum_mux   (.d(sum_data_c),   .sel(sel_c), .y_c(sum_c));
  fa_mux4 u_carry_mux (.d(carry_data_c), .sel(sel_c), .y_c(carry_c));

  always_comb begin
    s_d = sum_c;
    c_d = carry_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s = s_q;
  assign c = c_q;

`ifdef FA_SELFCHECK_EN
  logic [1:0] ref_d, ref_q;
  logic       err_d, err_q;

  // Reference is registered in step with s/c so both compare on the same edge.
  always_comb begin
    ref_d = 2'(a) + 2'(b) + 2'(cin);
    err_d = err_q | ({c_q, s_q} != ref_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= 2'b00;
      err_q <= 1'b0;
    end else begin
      ref_q <= ref_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif
endmodule

// File: tb/tb_fulladder_4to1mux.sv
// Randomised bench for fulladder_4to1mux with an arithmetic reference model
// and a few literal directed checks.

module tb_fulladder_4to1mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cin = 1'b1;
  logic a   = 1'b1;
  logic b   = 1'b1;
  logic s;
  logic c;

  int total = 0;
  int bad   = 0;

  logic       model_valid = 1'b0;
  logic [1:0] model_sum;

  fulladder_4to1mux dut (
    .clk(clk), .rst(rst), .cin(cin), .a(a), .b(b), .s(s), .c(c)
  );

  always #5 clk = ~clk;

  // Reference: the registered outputs equal the 2-bit sum of the last sampled inputs.
  always @(posedge clk) begin
    if (rst) begin
      model_sum   <= 2'd0;
      model_valid <= 1'b1;
    end else begin
      model_sum <= 2'(int'(a) + int'(b) + int'(cin));
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      total = total + 1;
      if ({c, s} !== model_sum) begin
        bad = bad + 1;
        $display("FAIL model_cmp t=%0t got {c,s}=%b%b want %b", $time, c, s, model_sum);
      end
    end
  end

  task automatic chk(input string name, input logic got_s, input logic got_c,
                     input logic want_s, input logic want_c);
    total = total + 1;
    if (got_s !== want_s || got_c !== want_c) begin
      bad = bad + 1;
      $display("FAIL %s got s=%b c=%b want s=%b c=%b", name, got_s, got_c, want_s, want_c);
    end
  endtask

  task automatic next_check();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sweep_s;
    logic [7:0] sweep_c;
    logic [2:0] v;
    sweep_s = 8'b1001_0110;
    sweep_c = 8'b1110_1000;

    // Reset with all operands high.
    rst = 1'b1; cin = 1'b1; a = 1'b1; b = 1'b1;
    next_check();
    chk("reset_cycle1", s, c, 1'b0, 1'b0);
    next_check();
    chk("reset_cycle2", s, c, 1'b0, 1'b0);

    // Exhaustive sweep of {cin,a,b}.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {cin, a, b} = v;
      next_check();
      chk($sformatf("sweep_%0d", i), s, c, sweep_s[i], sweep_c[i]);
    end

    // Input glitches around the edge: only the sampled value matters.
    cin = 1'b0; a = 1'b1; b = 1'b0;
    #2 b = 1'b1;
    @(posedge clk);
    #1 b = 1'b0;
    #2 b = 1'b1;
    #1 b = 1'b0;
    @(negedge clk);
    #1;
    chk("edge_sample", s, c, 1'b0, 1'b1);

    // Mid-stream reset discards the in-flight result.
    cin = 1'b1; a = 1'b1; b = 1'b0;
    next_check();
    chk("pre_reset", s, c, 1'b0, 1'b1);
    rst = 1'b1;
    next_check();
    chk("mid_reset", s, c, 1'b0, 1'b0);
    rst = 1'b0;
    next_check();
    chk("post_reset", s, c, 1'b0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      {cin, a, b} = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 15) == 0);
      next_check();
    end
    rst = 1'b0;
    next_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
